// File: rtl/fft_r22sdf_twiddle_mul.sv
// ============================================================================
// fft_r22sdf_twiddle_mul
//
// Purpose:
//   Twiddle-factor stage that sits directly after a radix-2^2 SDF BFII stage.
//   It multiplies each streamed complex sample by W_N^e. The exponent e comes
//   from an internal sample counter t:
//     q = t[MSB:MSB-1], m = t mod N/4
//     e = 0, 2m, m, 3m for q = 0, 1, 2, 3
//   The complex multiply is a fixed 4-stage pipeline with rounding. The
//   result is then narrowed to DATA_WIDTH. The output feeds the next BFI stage.
//
// Parameters:
//   DATA_WIDTH  signed width of the re/im samples on input and output
//   TW_WIDTH    signed twiddle width, Q1.(TW_WIDTH-1)
//   N           points spanned by this stage (power of 4, >= 16)
//
// Ports:
//   clk_i    in   clock; all logic runs on the rising edge
//   rst_i    in   asynchronous, active-high reset
//   valid_i  in   input sample valid
//   sync_i   in   first sample of a frame (only honoured with valid_i)
//   x_re_i   in   input real part, signed
//   x_im_i   in   input imaginary part, signed
//   valid_o  out  output sample valid (valid_i delayed by 4 cycles)
//   sync_o   out  sync delayed together with its sample
//   z_re_o   out  output real part, signed; holds while valid_o = 0
//   z_im_o   out  output imaginary part, signed; holds while valid_o = 0
//
// Configuration macro:
//   FFT_R22SDF_TW_SAT_EN  when defined, the final narrowing saturates to
//                         [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//                         When undefined, it keeps the low DATA_WIDTH bits
//                         (two's-complement wrap).
//                         The latency is 4 in both cases.
// ============================================================================
module fft_r22sdf_twiddle_mul #(
    parameter int DATA_WIDTH = 25,
    parameter int TW_WIDTH   = 10,
    parameter int N          = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic                         sync_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic                         sync_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o
);

    localparam int LOG_N = $clog2(N);
    localparam int PW    = DATA_WIDTH + TW_WIDTH;   // product width
    localparam int SW    = PW + 1;                  // sum-of-products width
    localparam int RW    = DATA_WIDTH + 2;          // width after the rounding shift

    // The value 2*pi in Q40. It is only used to build the twiddle table.
    localparam longint TWO_PI_Q40 = 64'sd6908435304715;

    localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (TW_WIDTH - 2));

    // ------------------------------------------------------------------------
    // Twiddle table entry for exponent idx.
    // The function returns either round(cos(2*pi*idx/N) * 2^(TW_WIDTH-1)) or
    // -round(sin(...) * same), clamped to +/-(2^(TW_WIDTH-1)-1).
    // It uses integer Q30 Taylor series on the first quadrant and then applies
    // quadrant symmetry. This keeps the table a pure elaboration-time constant
    // with no real arithmetic in the design.
    // ------------------------------------------------------------------------
    function automatic int tw_entry(input int idx, input bit imag);
        longint r, a, term, c, s, cv, sv, v, mag, lim;
        int     f_quad;
        f_quad = idx / (N / 4);
        r      = longint'(idx % (N / 4));
        a      = (TWO_PI_Q40 * r) / (longint'(N) * 64'sd1024);

        s    = a;
        term = a;
        for (int n = 1; n <= 12; n++) begin
            term = ((((term * a) >>> 30) * a) >>> 30) / longint'(2 * n * (2 * n + 1));
            s    = (n % 2 == 1) ? (s - term) : (s + term);
        end

        c    = 64'sd1 <<< 30;
        term = 64'sd1 <<< 30;
        for (int n = 1; n <= 12; n++) begin
            term = ((((term * a) >>> 30) * a) >>> 30) / longint'((2 * n - 1) * (2 * n));
            c    = (n % 2 == 1) ? (c - term) : (c + term);
        end

        case (f_quad)
            0:       begin cv =  c; sv =  s; end
            1:       begin cv = -s; sv =  c; end
            2:       begin cv = -c; sv = -s; end
            default: begin cv =  s; sv = -c; end
        endcase

        v   = imag ? -sv : cv;
        mag = (v < 0) ? -v : v;
        mag = ((mag <<< (TW_WIDTH - 1)) + (64'sd1 <<< 29)) >>> 30;
        lim = (64'sd1 <<< (TW_WIDTH - 1)) - 1;
        if (mag > lim) begin
            mag = lim;
        end
        return int'((v < 0) ? -mag : mag);
    endfunction

    logic signed [TW_WIDTH-1:0] rom_re [N];
    logic signed [TW_WIDTH-1:0] rom_im [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam int RE_VAL = tw_entry(g, 1'b0);
        localparam int IM_VAL = tw_entry(g, 1'b1);
        assign rom_re[g] = TW_WIDTH'(RE_VAL);
        assign rom_im[g] = TW_WIDTH'(IM_VAL);
    end

    // ------------------------------------------------------------------------
    // Sample counter and exponent.
    // A qualified sync forces the current sample to use t = 0.
    // ------------------------------------------------------------------------
    logic [LOG_N-1:0] cnt;
    logic [LOG_N-1:0] t_cur;
    logic [LOG_N-1:0] m_val;
    logic [LOG_N-1:0] e_cur;
    logic [1:0]       quad;

    always_comb begin
        t_cur = sync_i ? '0 : cnt;
        quad  = t_cur[LOG_N-1 -: 2];
        m_val = {2'b00, t_cur[LOG_N-3:0]};
        e_cur = '0;
        case (quad)
            2'd0:    e_cur = '0;
            2'd1:    e_cur = m_val << 1;
            2'd2:    e_cur = m_val;
            default: e_cur = m_val + (m_val << 1);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (valid_i) begin
            cnt <= t_cur + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stages 1 to 3: capture the sample, look up the twiddle, form the products.
    // ------------------------------------------------------------------------
    logic                         valid_s1, sync_s1, valid_s2, sync_s2, valid_s3, sync_s3;
    logic signed [DATA_WIDTH-1:0] x_re_s1, x_im_s1, x_re_s2, x_im_s2;
    logic [LOG_N-1:0]             e_s1;
    logic signed [TW_WIDTH-1:0]   wr_s2, wi_s2;
    logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_s1 <= 1'b0;
            sync_s1  <= 1'b0;
            x_re_s1  <= '0;
            x_im_s1  <= '0;
            e_s1     <= '0;
            valid_s2 <= 1'b0;
            sync_s2  <= 1'b0;
            x_re_s2  <= '0;
            x_im_s2  <= '0;
            wr_s2    <= '0;
            wi_s2    <= '0;
            valid_s3 <= 1'b0;
            sync_s3  <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else begin
            valid_s1 <= valid_i;
            sync_s1  <= valid_i & sync_i;
            x_re_s1  <= x_re_i;
            x_im_s1  <= x_im_i;
            e_s1     <= e_cur;

            valid_s2 <= valid_s1;
            sync_s2  <= sync_s1;
            x_re_s2  <= x_re_s1;
            x_im_s2  <= x_im_s1;
            wr_s2    <= rom_re[e_s1];
            wi_s2    <= rom_im[e_s1];

            valid_s3 <= valid_s2;
            sync_s3  <= sync_s2;
            p_rr     <= PW'(x_re_s2) * PW'(wr_s2);
            p_ii     <= PW'(x_im_s2) * PW'(wi_s2);
            p_ri     <= PW'(x_re_s2) * PW'(wi_s2);
            p_ir     <= PW'(x_im_s2) * PW'(wr_s2);
        end
    end

    // ------------------------------------------------------------------------
    // Stage 4: combine the products, round half-up, then narrow the result.
    // ------------------------------------------------------------------------
`ifdef FFT_R22SDF_TW_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [RW-1:0] v);
        if (v > RW'(D_MAX)) begin
            return D_MAX;
        end else if (v < RW'(D_MIN)) begin
            return D_MIN;
        end
        return DATA_WIDTH'(v);
    endfunction
`else
    function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [RW-1:0] v);
        return DATA_WIDTH'(v);
    endfunction
`endif

    logic signed [SW-1:0]         sum_re, sum_im;
    logic signed [RW-1:0]         rnd_re, rnd_im;
    logic signed [DATA_WIDTH-1:0] nar_re, nar_im;

    always_comb begin
        sum_re = SW'(p_rr) - SW'(p_ii) + RND;
        sum_im = SW'(p_ri) + SW'(p_ir) + RND;
        rnd_re = RW'(sum_re >>> (TW_WIDTH - 1));
        rnd_im = RW'(sum_im >>> (TW_WIDTH - 1));
        nar_re = narrow(rnd_re);
        nar_im = narrow(rnd_im);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            sync_o  <= 1'b0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else begin
            valid_o <= valid_s3;
            sync_o  <= sync_s3;
            if (valid_s3) begin
                z_re_o <= nar_re;
                z_im_o <= nar_im;
            end
        end
    end

endmodule
